// File: rtl/pulse_shaper_if.sv
// Trigger/shaping bus between a pulse_shaper and whatever drives it.
interface pulse_shaper_if #(
    parameter int unsigned CNT_W = 8
);
    logic             data_in;
    logic [CNT_W-1:0] dly;
    logic [CNT_W-1:0] wid;
    logic             retrig_en;
    logic             data_out;
    logic             busy;
    logic             done;
    logic             overrun;

    modport master (
        output data_in, dly, wid, retrig_en,
        input  data_out, busy, done, overrun
    );

    modport slave (
        input  data_in, dly, wid, retrig_en,
        output data_out, busy, done, overrun
    );
endinterface

// File: rtl/pulse_shaper.sv
// Delayed, width-programmable pulse generator with optional retrigger.
module pulse_shaper #(
    parameter int unsigned CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    pulse_shaper_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] dly_cnt_q, dly_cnt_d;
    logic [CNT_W-1:0] wid_lat_q, wid_lat_d;
    logic [CNT_W-1:0] wid_cnt_q, wid_cnt_d;
    logic             data_out_q, data_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] wid_eff_c;

    // A requested width of zero still produces a single high cycle.
    assign wid_eff_c = (bus.wid == '0) ? CNT_W'(1) : bus.wid;

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dly_cnt_q  <= '0;
            wid_lat_q  <= '0;
            wid_cnt_q  <= '0;
            data_out_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dly_cnt_q  <= dly_cnt_d;
            wid_lat_q  <= wid_lat_d;
            wid_cnt_q  <= wid_cnt_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    // Next state; counters hold the remaining cycles including the current one.
    always_comb begin
        state_d   = state_q;
        dly_cnt_d = dly_cnt_q;
        wid_lat_d = wid_lat_q;
        wid_cnt_d = wid_cnt_q;
        done_d    = 1'b0;
        overrun_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.data_in) begin
                    dly_cnt_d = bus.dly;
                    wid_lat_d = wid_eff_c;
                    if (bus.dly == '0) begin
                        state_d   = ACTIVE;
                        wid_cnt_d = wid_eff_c;
                    end else begin
                        state_d = DELAY;
                    end
                end
            end
            DELAY: begin
                overrun_d = bus.data_in;
                if (dly_cnt_q <= CNT_W'(1)) begin
                    state_d   = ACTIVE;
                    wid_cnt_d = wid_lat_q;
                end else begin
                    dly_cnt_d = dly_cnt_q - CNT_W'(1);
                end
            end
            ACTIVE: begin
                if (bus.data_in && bus.retrig_en) begin
                    wid_cnt_d = wid_eff_c;
                end else begin
                    overrun_d = bus.data_in;
                    if (wid_cnt_q <= CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        wid_cnt_d = wid_cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        data_out_d = (state_d == ACTIVE);
        busy_d     = (state_d != IDLE);
    end

    assign bus.data_out = data_out_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_pulse_shaper.sv
// Directed checks of pulse_shaper timing, retrigger, overrun and reset behaviour.
module tb_pulse_shaper;

    localparam int unsigned CNT_W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pulse_shaper_if #(.CNT_W(CNT_W)) bus ();

    pulse_shaper #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Check all four outputs in the current cycle, then advance one cycle.
    task automatic cyc(input string tag, input logic e_do, input logic e_busy,
                       input logic e_done, input logic e_ovr);
        chk({tag, ".data_out"}, bus.data_out, e_do);
        chk({tag, ".busy"},     bus.busy,     e_busy);
        chk({tag, ".done"},     bus.done,     e_done);
        chk({tag, ".overrun"},  bus.overrun,  e_ovr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.data_in   = 1'b0;
        bus.dly       = '0;
        bus.wid       = '0;
        bus.retrig_en = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        cyc("rst", 0, 0, 0, 0);
        rst_n = 1'b1;

        // dly=0 wid=3
        bus.dly = 8'd0; bus.wid = 8'd3; bus.data_in = 1'b1;
        cyc("d0w3.N", 0, 0, 0, 0);
        bus.data_in = 1'b0;
        cyc("d0w3.N1", 1, 1, 0, 0);
        cyc("d0w3.N2", 1, 1, 0, 0);
        cyc("d0w3.N3", 1, 1, 0, 0);
        cyc("d0w3.N4", 0, 0, 1, 0);
        cyc("d0w3.N5", 0, 0, 0, 0);

        // dly=4 wid=2, inputs changed after acceptance
        bus.dly = 8'd4; bus.wid = 8'd2; bus.data_in = 1'b1;
        cyc("d4w2.N", 0, 0, 0, 0);
        bus.data_in = 1'b0; bus.dly = 8'd0; bus.wid = 8'd0;
        cyc("d4w2.N1", 0, 1, 0, 0);
        cyc("d4w2.N2", 0, 1, 0, 0);
        cyc("d4w2.N3", 0, 1, 0, 0);
        cyc("d4w2.N4", 0, 1, 0, 0);
        cyc("d4w2.N5", 1, 1, 0, 0);
        cyc("d4w2.N6", 1, 1, 0, 0);
        cyc("d4w2.N7", 0, 0, 1, 0);
        cyc("d4w2.N8", 0, 0, 0, 0);

        // wid=0 behaves as one cycle
        bus.dly = 8'd0; bus.wid = 8'd0; bus.data_in = 1'b1;
        cyc("w0.N", 0, 0, 0, 0);
        bus.data_in = 1'b0;
        cyc("w0.N1", 1, 1, 0, 0);
        cyc("w0.N2", 0, 0, 1, 0);
        cyc("w0.N3", 0, 0, 0, 0);

        // dly=1 wid=1
        bus.dly = 8'd1; bus.wid = 8'd1; bus.data_in = 1'b1;
        cyc("d1w1.N", 0, 0, 0, 0);
        bus.data_in = 1'b0;
        cyc("d1w1.N1", 0, 1, 0, 0);
        cyc("d1w1.N2", 1, 1, 0, 0);
        cyc("d1w1.N3", 0, 0, 1, 0);

        // Maximum delay and width, no wrap
        bus.dly = 8'd255; bus.wid = 8'd255; bus.data_in = 1'b1;
        cyc("max.N", 0, 0, 0, 0);
        bus.data_in = 1'b0;
        for (int i = 0; i < 255; i++) cyc("max.dly", 0, 1, 0, 0);
        for (int i = 0; i < 255; i++) cyc("max.wid", 1, 1, 0, 0);
        cyc("max.end", 0, 0, 1, 0);
        cyc("max.idle", 0, 0, 0, 0);

        // Retrigger extends the pulse
        bus.dly = 8'd0; bus.wid = 8'd4; bus.retrig_en = 1'b1; bus.data_in = 1'b1;
        cyc("rt1.N", 0, 0, 0, 0);
        bus.data_in = 1'b0;
        cyc("rt1.N1", 1, 1, 0, 0);
        cyc("rt1.N2", 1, 1, 0, 0);
        bus.data_in = 1'b1;
        cyc("rt1.N3", 1, 1, 0, 0);
        bus.data_in = 1'b0;
        cyc("rt1.N4", 1, 1, 0, 0);
        cyc("rt1.N5", 1, 1, 0, 0);
        cyc("rt1.N6", 1, 1, 0, 0);
        cyc("rt1.N7", 1, 1, 0, 0);
        cyc("rt1.N8", 0, 0, 1, 0);
        cyc("rt1.N9", 0, 0, 0, 0);

        // Same with retrigger disabled: overrun, unchanged length
        bus.retrig_en = 1'b0; bus.data_in = 1'b1;
        cyc("rt0.N", 0, 0, 0, 0);
        bus.data_in = 1'b0;
        cyc("rt0.N1", 1, 1, 0, 0);
        cyc("rt0.N2", 1, 1, 0, 0);
        bus.data_in = 1'b1;
        cyc("rt0.N3", 1, 1, 0, 0);
        bus.data_in = 1'b0;
        cyc("rt0.N4", 1, 1, 0, 1);
        cyc("rt0.N5", 0, 0, 1, 0);
        cyc("rt0.N6", 0, 0, 0, 0);

        // Trigger during DELAY is dropped
        bus.dly = 8'd3; bus.wid = 8'd1; bus.data_in = 1'b1;
        cyc("dov.N", 0, 0, 0, 0);
        cyc("dov.N1", 0, 1, 0, 0);
        bus.data_in = 1'b0;
        cyc("dov.N2", 0, 1, 0, 1);
        cyc("dov.N3", 0, 1, 0, 0);
        cyc("dov.N4", 1, 1, 0, 0);
        cyc("dov.N5", 0, 0, 1, 0);
        cyc("dov.N6", 0, 0, 0, 0);

        // Trigger held high: 2 high, 1 low, repeating
        bus.dly = 8'd0; bus.wid = 8'd2; bus.data_in = 1'b1;
        cyc("hold.N", 0, 0, 0, 0);
        cyc("hold.N1", 1, 1, 0, 0);
        cyc("hold.N2", 1, 1, 0, 1);
        cyc("hold.N3", 0, 0, 1, 1);
        cyc("hold.N4", 1, 1, 0, 0);
        cyc("hold.N5", 1, 1, 0, 1);
        bus.data_in = 1'b0;
        cyc("hold.N6", 0, 0, 1, 1);
        cyc("hold.N7", 0, 0, 0, 0);

        // Asynchronous reset mid-ACTIVE
        bus.dly = 8'd0; bus.wid = 8'd5; bus.data_in = 1'b1;
        cyc("arst.N", 0, 0, 0, 0);
        bus.data_in = 1'b0;
        cyc("arst.N1", 1, 1, 0, 0);
        chk("arst.pre.data_out", bus.data_out, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.imm.data_out", bus.data_out, 1'b0);
        chk("arst.imm.busy",     bus.busy,     1'b0);
        chk("arst.imm.done",     bus.done,     1'b0);
        @(posedge clk);
        #1;
        cyc("arst.held", 0, 0, 0, 0);
        rst_n = 1'b1;
        bus.wid = 8'd2; bus.data_in = 1'b1;
        cyc("arst.R", 0, 0, 0, 0);
        bus.data_in = 1'b0;
        cyc("arst.R1", 1, 1, 0, 0);
        cyc("arst.R2", 1, 1, 0, 0);
        cyc("arst.R3", 0, 0, 1, 0);
        cyc("arst.R4", 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_shaper.md
PULSE_SHAPER -- requirements
Module: pulse_shaper

Interface
REQ-001 Parameter: CNT_W, 8, width of the delay and width counters and of dly/wid.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: data_in  input  1  trigger request; every clk cycle sampled high is one trigger (normally a 1-cycle edge pulse).
REQ-005 Port: dly  input  CNT_W  cycles from trigger acceptance to the first data_out high cycle, minus one.
REQ-006 Port: wid  input  CNT_W  number of cycles data_out is held high; 0 is treated as 1.
REQ-007 Port: retrig_en  input  1  1 = a trigger during the ACTIVE state extends the pulse.
REQ-008 Port: data_out  output  1  registered shaped pulse.
REQ-009 Port: busy  output  1  registered; high while the FSM is in DELAY or ACTIVE.
REQ-010 Port: done  output  1  registered; 1-cycle pulse marking the end of a pulse.
REQ-011 Port: overrun  output  1  registered; 1-cycle pulse marking a dropped trigger.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, DELAY and ACTIVE; the encoding is free.
REQ-013 In IDLE, data_in=1 at cycle N SHALL latch dly and wid into internal registers and SHALL set busy=1 from cycle N+1.
REQ-014 On acceptance with latched dly=0, the FSM SHALL enter ACTIVE and data_out SHALL be 1 from cycle N+1.
REQ-015 On acceptance with latched dly=D>0, the FSM SHALL enter DELAY, data_out SHALL stay 0 for cycles N+1..N+D, and data_out SHALL rise at N+1+D.
REQ-016 In ACTIVE, data_out SHALL stay high for exactly W cycles, where W = max(latched wid, 1), then the FSM SHALL return to IDLE.
REQ-017 In the first cycle after the last data_out high cycle, data_out SHALL be 0, busy SHALL be 0 and done SHALL be 1 for exactly one cycle.
REQ-018 Changes to dly or wid after acceptance SHALL NOT affect the pulse in progress, except as stated in REQ-020.
REQ-019 data_in=1 while in DELAY SHALL be ignored, and overrun SHALL be 1 in the following cycle only.
REQ-020 data_in=1 while in ACTIVE with retrig_en=1 SHALL reload the width counter with max(current wid,1) and keep data_out high for that many further cycles from the next cycle; overrun SHALL stay 0 and done SHALL NOT assert until the extended pulse ends.
REQ-021 data_in=1 while in ACTIVE with retrig_en=0 SHALL be ignored, and overrun SHALL pulse for one cycle; the pulse length is unchanged.
REQ-022 data_in=1 in the same cycle that done=1 SHALL be accepted as in REQ-013; the minimum low gap between pulses is therefore one cycle.
REQ-023 The counters SHALL be CNT_W bits and SHALL never wrap; the maximum pulse width and the maximum delay are each 2^CNT_W-1 cycles.
REQ-024 data_out, busy, done and overrun SHALL be driven directly from flops, with no combinational path from any input.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, data_out=0, busy=0, done=0, overrun=0, and clear the latched dly/wid values and both counters.
REQ-026 A reset during DELAY or ACTIVE SHALL abort the pulse with no done pulse; after rst_n rises, the first trigger SHALL behave as in REQ-013.
REQ-027 The block SHALL accept a trigger on the first rising clk edge after rst_n is deasserted.

Verification
REQ-028 dly=0, wid=3, 1-cycle trigger at N -> data_out=1 at N+1..N+3; done=1 at N+4; busy=1 at N+1..N+3.
REQ-029 dly=4, wid=2, trigger at N; dly/wid changed to 0 at N+1 -> data_out=1 at N+5..N+6; done at N+7.
REQ-030 wid=0 -> data_out high for exactly 1 cycle; dly=255, wid=255 (CNT_W=8) -> 255 low cycles followed by 255 high cycles, with no wrap.
REQ-031 retrig_en=1, dly=0, wid=4, triggers at N and N+3 -> data_out=1 at N+1..N+7; a single done at N+8; overrun stays 0. Repeat with retrig_en=0 -> data_out at N+1..N+4 and overrun=1 at N+4.
REQ-032 Trigger at N during DELAY -> overrun=1 at N+1 only, with unchanged timing; trigger held high continuously with dly=0, wid=2 -> pulses high 2 cycles and low 1 cycle, repeating, with done and overrun as specified.
REQ-033 rst_n pulsed low mid-ACTIVE (asynchronously, between edges) -> data_out and busy drop immediately with no done; a trigger after release produces a correct full pulse.
